// File: rtl/stim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stim_pkg
// Brief    : Shared types and constants for the stimulus sweep generator:
//            FSM state encoding, signature width and signature step function.
// Revision : 1.0 - initial release
// ============================================================================
package stim_pkg;

    // Sweep controller states, explicitly two bits wide.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Width of the response signature register.
    localparam int SIG_W = 16;

    // One signature step: rotate left by one, then fold in the response.
    function automatic logic [SIG_W-1:0] sig_step(
        input logic [SIG_W-1:0] cur,
        input logic [SIG_W-1:0] rsp_ext
    );
        return {cur[SIG_W-2:0], cur[SIG_W-1]} ^ rsp_ext;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stim_sig_acc.sv
`default_nettype none
// ============================================================================
// Module   : stim_sig_acc
// Brief    : Response signature accumulator. Clears on request and, on each
//            step strobe, rotates the signature left and XORs in the
//            zero-extended DUT response.
// Revision : 1.0 - initial release
// ============================================================================
module stim_sig_acc
    import stim_pkg::*;
#(
    parameter int RSP_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    input  logic [RSP_W-1:0] rsp,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] w_rsp_ext;
    logic [SIG_W-1:0] r_sig;

    // Zero-extend the response to the signature width.
    always_comb begin
        w_rsp_ext             = '0;
        w_rsp_ext[RSP_W-1:0] = rsp;
    end

    // Signature register: clear has priority over a step in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig <= '0;
        end else if (clear) begin
            r_sig <= '0;
        end else if (step) begin
            r_sig <= sig_step(r_sig, w_rsp_ext);
        end
    end

    assign sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/stim_sweep_gen.sv
`default_nettype none
// ============================================================================
// Module   : stim_sweep_gen
// Brief    : Exhaustive stimulus sweep generator. On start, drives every
//            WIDTH-bit vector from 0 up to all-ones, holding each for HOLD
//            unstalled cycles, then pulses done for one cycle.
//            Optional feature macro: STIM_SWEEP_SIGNATURE_EN adds the sig
//            port and a response signature accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module stim_sweep_gen
    import stim_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int HOLD  = 10,
    parameter int RSP_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    input  logic [RSP_W-1:0] rsp,
    output logic [WIDTH-1:0] vec,
    output logic             vec_valid,
    output logic             last,
    output logic             busy,
    output logic             done
`ifdef STIM_SWEEP_SIGNATURE_EN
   ,output logic [SIG_W-1:0] sig
`endif
);

    // Hold counter needs at least one bit even when HOLD is 1.
    localparam int               CNT_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_vec;
    logic [CNT_W-1:0] r_cnt;

    logic w_accept;     // start sampled in IDLE
    logic w_run;        // DRIVE and not stalled
    logic w_hold_end;   // current vector has been held its full time
    logic w_all_ones;

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_run      = (r_state == ST_DRIVE) && !stall;
    assign w_hold_end = w_run && (r_cnt == CNT_LAST);
    assign w_all_ones = &r_vec;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: DONE lasts exactly one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_DRIVE;
            ST_DRIVE: if (w_hold_end && w_all_ones) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Vector and hold counter; the vector stops at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_vec <= '0;
            r_cnt <= '0;
        end else if (w_hold_end) begin
            r_cnt <= '0;
            if (!w_all_ones) begin
                r_vec <= r_vec + WIDTH'(1);
            end
        end else if (w_run) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign vec       = r_vec;
    assign vec_valid = (r_state == ST_DRIVE);
    assign busy      = (r_state == ST_DRIVE);
    assign last      = (r_state == ST_DRIVE) && w_all_ones;
    assign done      = (r_state == ST_DONE);

`ifdef STIM_SWEEP_SIGNATURE_EN
    // Signature folds in the response once per vector, at its hold end.
    stim_sig_acc #(
        .RSP_W (RSP_W)
    ) u_sig_acc (
        .clk   (clk),
        .rst   (rst),
        .clear (w_accept),
        .step  (w_hold_end),
        .rsp   (rsp),
        .sig   (sig)
    );
`else
    // Response is only consumed by the signature accumulator.
    logic w_unused_rsp;
    assign w_unused_rsp = ^rsp;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stim_sweep_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_stim_sweep_gen
// Brief    : Self-checking bench for stim_sweep_gen. Instance A uses the
//            default 6-bit / hold-10 setup, instance B is 2-bit / hold-1.
//            Honours STIM_SWEEP_SIGNATURE_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stim_sweep_gen;
    import stim_pkg::*;

    localparam int W_A    = 6;
    localparam int HOLD_A = 10;
    localparam int W_B    = 2;
    localparam int HOLD_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           start_a, stall_a, start_b, stall_b;
    logic [2:0]     rsp_a, rsp_b;
    logic [W_A-1:0] vec_a;
    logic [W_B-1:0] vec_b;
    logic           valid_a, last_a, busy_a, done_a;
    logic           valid_b, last_b, busy_b, done_b;
`ifdef STIM_SWEEP_SIGNATURE_EN
    logic [SIG_W-1:0] sig_a, sig_b;
`endif

    stim_sweep_gen #(.WIDTH(W_A), .HOLD(HOLD_A), .RSP_W(3)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stall(stall_a), .rsp(rsp_a),
        .vec(vec_a), .vec_valid(valid_a), .last(last_a), .busy(busy_a), .done(done_a)
`ifdef STIM_SWEEP_SIGNATURE_EN
       ,.sig(sig_a)
`endif
    );

    stim_sweep_gen #(.WIDTH(W_B), .HOLD(HOLD_B), .RSP_W(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stall(stall_b), .rsp(rsp_b),
        .vec(vec_b), .vec_valid(valid_b), .last(last_b), .busy(busy_b), .done(done_b)
`ifdef STIM_SWEEP_SIGNATURE_EN
       ,.sig(sig_b)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Sweep scenario: optional stall injected when a given vector first
    // appears, optional start re-pulse while busy, and the expected timing
    // counted in cycles after the start-sampling edge (cycle 1 follows it).
    typedef struct {
        int stall_vec;
        int stall_len;
        int restart_vec;
        int exp_done_cyc;
        int exp_busy;
    } scen_t;

    // Scoreboard entry: one vector and how many cycles it should be shown.
    typedef struct {
        int v;
        int len;
    } run_t;

    run_t exp_q[$];

    // Vector-level expectation for instance B, one entry per cycle.
    typedef struct {
        int          v;
        logic        valid;
        logic        lst;
        logic        bsy;
        logic        dn;
        logic [15:0] sg;
    } cyc_t;

    task automatic close_run(input int v, input int len);
        run_t r;
        if (exp_q.size() == 0) begin
            chk("unexpected_run", v, -1);
        end else begin
            r = exp_q.pop_front();
            chk("run_vec", v, r.v);
            chk("run_len", len, r.len);
        end
    endtask

    task automatic run_scen(input scen_t s, input int idx);
        int   cyc, busy_n, last_n, run_v, run_len, stall_passed, done_cyc;
        bit   stall_started, restarted;
        logic done_busy, done_valid;
        logic [15:0] exp_sig;
        run_t r;
`ifdef STIM_SWEEP_SIGNATURE_EN
        logic [15:0] sig_at_done;
        sig_at_done = '0;
`endif
        exp_q.delete();
        exp_sig = '0;
        for (int v = 0; v < (1 << W_A); v++) begin
            r.v   = v;
            r.len = HOLD_A + ((v == s.stall_vec) ? s.stall_len : 0);
            exp_q.push_back(r);
            exp_sig = {exp_sig[14:0], exp_sig[15]} ^ {13'd0, rsp_a};
        end
        cyc = 0; busy_n = 0; last_n = 0; run_v = 0; run_len = 0;
        stall_passed = 0; done_cyc = -1; stall_started = 0; restarted = 0;
        done_busy = 1'b1; done_valid = 1'b1;

        @(negedge clk);
        start_a = 1'b1;
        while (done_cyc < 0 && cyc < 800) begin
            @(negedge clk);
            cyc++;
            start_a = 1'b0;
            if (stall_a) begin
                stall_passed++;
                if (stall_passed == s.stall_len) stall_a = 1'b0;
            end
            if (busy_a) busy_n++;
            if (last_a) last_n++;
            if (valid_a) begin
                if (run_len > 0 && int'(vec_a) != run_v) begin
                    close_run(run_v, run_len);
                    run_len = 0;
                end
                run_v = int'(vec_a);
                run_len++;
            end else if (run_len > 0) begin
                close_run(run_v, run_len);
                run_len = 0;
            end
            if (done_a) begin
                done_cyc   = cyc;
                done_busy  = busy_a;
                done_valid = valid_a;
`ifdef STIM_SWEEP_SIGNATURE_EN
                sig_at_done = sig_a;
`endif
            end
            if (valid_a && int'(vec_a) == s.stall_vec && !stall_started) begin
                stall_a       = 1'b1;
                stall_started = 1'b1;
            end
            if (valid_a && int'(vec_a) == s.restart_vec && !restarted) begin
                start_a   = 1'b1;
                restarted = 1'b1;
            end
        end
        if (done_cyc < 0) begin
            chk($sformatf("s%0d_timeout", idx), cyc, s.exp_done_cyc);
        end else begin
            chk($sformatf("s%0d_done_cyc", idx), done_cyc, s.exp_done_cyc);
            chk($sformatf("s%0d_busy_cycles", idx), busy_n, s.exp_busy);
            chk($sformatf("s%0d_last_cycles", idx), last_n,
                HOLD_A + ((s.stall_vec == 63) ? s.stall_len : 0));
            chk($sformatf("s%0d_busy_in_done", idx), done_busy, 0);
            chk($sformatf("s%0d_valid_in_done", idx), done_valid, 0);
            chk($sformatf("s%0d_runs_left", idx), exp_q.size(), 0);
`ifdef STIM_SWEEP_SIGNATURE_EN
            chk($sformatf("s%0d_sig", idx), sig_at_done, exp_sig);
`endif
            @(negedge clk);
            chk($sformatf("s%0d_done_one_cycle", idx), done_a, 0);
            chk($sformatf("s%0d_vec_no_wrap", idx), vec_a, 63);
        end
        stall_a = 1'b0;
        start_a = 1'b0;
    endtask

    scen_t scen_tbl[5];
    cyc_t  b_tbl[6];

    initial begin
        int wait_n;

        // Timing constants follow directly from 64 vectors x 10 cycles.
        scen_tbl[0] = '{stall_vec: -1, stall_len: 0, restart_vec: -1, exp_done_cyc: 641, exp_busy: 640};
        scen_tbl[1] = '{stall_vec:  3, stall_len: 5, restart_vec: -1, exp_done_cyc: 646, exp_busy: 645};
        scen_tbl[2] = '{stall_vec: -1, stall_len: 0, restart_vec: 10, exp_done_cyc: 641, exp_busy: 640};
        scen_tbl[3] = '{stall_vec:  0, stall_len: 1, restart_vec: -1, exp_done_cyc: 642, exp_busy: 641};
        scen_tbl[4] = '{stall_vec: 63, stall_len: 3, restart_vec: 40, exp_done_cyc: 644, exp_busy: 643};

        // 2-bit, hold-1 sweep with rsp=1: signature shifts in a one per vector.
        b_tbl[0] = '{v: 0, valid: 1, lst: 0, bsy: 1, dn: 0, sg: 16'h0000};
        b_tbl[1] = '{v: 1, valid: 1, lst: 0, bsy: 1, dn: 0, sg: 16'h0001};
        b_tbl[2] = '{v: 2, valid: 1, lst: 0, bsy: 1, dn: 0, sg: 16'h0003};
        b_tbl[3] = '{v: 3, valid: 1, lst: 1, bsy: 1, dn: 0, sg: 16'h0007};
        b_tbl[4] = '{v: 3, valid: 0, lst: 0, bsy: 0, dn: 1, sg: 16'h000F};
        b_tbl[5] = '{v: 3, valid: 0, lst: 0, bsy: 0, dn: 0, sg: 16'h000F};

        rst = 1'b1; start_a = 1'b1; stall_a = 1'b1; start_b = 1'b1; stall_b = 1'b0;
        rsp_a = 3'b101; rsp_b = 3'b001;

        // Reset, with start and stall held high to show reset priority.
        repeat (3) @(negedge clk);
        chk("rst_vec_a", vec_a, 0);
        chk("rst_valid_a", valid_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_last_a", last_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_busy_b", busy_b, 0);
`ifdef STIM_SWEEP_SIGNATURE_EN
        chk("rst_sig_a", sig_a, 0);
`endif
        rst = 1'b0; start_b = 1'b0;

        // Stall is ignored in IDLE: start with stall high still enters DRIVE.
        @(negedge clk);
        chk("idle_stall_busy", busy_a, 1);
        chk("idle_stall_vec", vec_a, 0);
        start_a = 1'b0;
        repeat (20) @(negedge clk);
        chk("stalled_vec_held", vec_a, 0);
        chk("stalled_busy", busy_a, 1);
        stall_a = 1'b0;

        // Reset in the middle of a sweep, at vec=20.
        wait_n = 0;
        while (vec_a != 6'd20 && wait_n < 400) begin
            @(negedge clk);
            wait_n++;
        end
        chk("reach_vec20", vec_a, 20);
        rst = 1'b1; start_a = 1'b1;
        @(negedge clk);
        chk("midrst_vec", vec_a, 0);
        chk("midrst_valid", valid_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_last", last_a, 0);
        chk("midrst_done", done_a, 0);
`ifdef STIM_SWEEP_SIGNATURE_EN
        chk("midrst_sig", sig_a, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        start_a = 1'b0;
        chk("restart_busy", busy_a, 1);
        chk("restart_vec", vec_a, 0);
        repeat (10) @(negedge clk);
        chk("restart_vec_after_hold", vec_a, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full sweeps through the scenario table.
        for (int i = 0; i < 5; i++) begin
            run_scen(scen_tbl[i], i);
            repeat (2) @(negedge clk);
        end

        // Instance B: 2-bit, hold-1 sweep, one vector per cycle.
        start_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start_b = 1'b0;
            stall_b = (i == 4);  // stall during DONE must not extend it
            chk($sformatf("b%0d_vec", i), vec_b, b_tbl[i].v);
            chk($sformatf("b%0d_valid", i), valid_b, b_tbl[i].valid);
            chk($sformatf("b%0d_last", i), last_b, b_tbl[i].lst);
            chk($sformatf("b%0d_busy", i), busy_b, b_tbl[i].bsy);
            chk($sformatf("b%0d_done", i), done_b, b_tbl[i].dn);
`ifdef STIM_SWEEP_SIGNATURE_EN
            chk($sformatf("b%0d_sig", i), sig_b, b_tbl[i].sg);
`endif
        end
        stall_b = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stim_sweep_gen.md
STIM_SWEEP_GEN -- requirements
Module: stim_sweep_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 6: stimulus vector width (DUT input count).
REQ-002 SHALL have parameter HOLD, default 10: cycles each vector is held; legal range 1..1023.
REQ-003 SHALL have parameter RSP_W, default 3: DUT response width; legal range 1..16.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: sweep request; sampled only in IDLE.
REQ-007 SHALL have port stall, input, 1: freezes the sweep while high.
REQ-008 SHALL have port rsp, input, RSP_W: DUT response to the current vector.
REQ-009 SHALL have port vec, output, WIDTH: stimulus vector driven to the DUT.
REQ-010 SHALL have port vec_valid, output, 1: vec is a live stimulus.
REQ-011 SHALL have port last, output, 1: vec is the final (all-ones) vector.
REQ-012 SHALL have port busy, output, 1: sweep in progress.
REQ-013 SHALL have port done, output, 1: one-cycle pulse at sweep completion.
REQ-014 SHALL have port sig, output, 16: response signature; present only with SIGNATURE_EN.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, DONE.
REQ-016 In IDLE, start=1 SHALL move to DRIVE next cycle with vec=0 and hold counter=0.
REQ-017 In DRIVE, vec_valid and busy SHALL be 1; in IDLE and DONE both SHALL be 0.
REQ-018 In DRIVE, when stall=0, the hold counter SHALL increment each cycle.
REQ-019 In DRIVE, when hold counter=HOLD-1 and stall=0 and vec is not all ones, vec SHALL increment by 1 and the hold counter SHALL clear.
REQ-020 In DRIVE, when hold counter=HOLD-1, stall=0 and vec is all ones, the FSM SHALL go to DONE; vec SHALL NOT wrap.
REQ-021 With stall=1, vec, the hold counter and the state SHALL hold; stall SHALL have no effect in IDLE or DONE.
REQ-022 last SHALL equal (state==DRIVE && vec all ones).
REQ-023 done SHALL be 1 for exactly the single DONE cycle; the FSM SHALL then return to IDLE.
REQ-024 start outside IDLE SHALL be ignored.
REQ-025 Unstalled sweep length SHALL be exactly 2^WIDTH*HOLD DRIVE cycles.
REQ-026 HOLD=1 SHALL advance vec every unstalled cycle.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, vec=0, hold counter=0, vec_valid=0, last=0, busy=0, done=0, sig=0, regardless of state, including mid-sweep.
REQ-028 rst SHALL take priority over start and stall.

Configuration
REQ-029 With macro STIM_SWEEP_SIGNATURE_EN defined, port sig and its accumulator SHALL exist. Without it, neither SHALL exist and all other behaviour is unchanged.
REQ-030 Accumulator update: sig clears when start is accepted. On each DRIVE cycle with hold counter=HOLD-1 and stall=0, sig <= {sig[14:0],sig[15]} XOR zero-extended rsp.

Structure
REQ-031 Package stim_pkg SHALL hold the FSM state typedef and constant SIG_W=16.
REQ-032 The signature accumulator SHALL be sub-module stim_sig_acc, instantiated only under STIM_SWEEP_SIGNATURE_EN.

Verification
REQ-033 WIDTH=6, HOLD=10, start pulse: vec 0..63 each held 10 cycles; done pulses 641 cycles after the start-sampling edge; busy is high for 640 cycles.
REQ-034 Same setup, stall high 5 cycles during vec=3: vec=3 is held 15 cycles and done arrives 5 cycles late (646 cycles after start).
REQ-035 start re-asserted while busy: vector sequence and done timing are identical to REQ-033.
REQ-036 rst asserted while vec=20: next cycle vec=0, vec_valid=0, busy=0; a new start restarts the sweep at 0.
REQ-037 WIDTH=2, HOLD=1, macro defined, rsp=3'b001: sig progresses 0x0001, 0x0003, 0x0007, 0x000F; sig=0x000F when done is high; last is high for 1 cycle.
